// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned          INSTR_W       = 32;
  localparam int unsigned          MEM_BYTES_DEF = 256;
  localparam logic [31:0]          RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0]   NOP           = '0;

  // What the IF/ID register does at the next edge.
  typedef enum logic [1:0] {
    IFID_CAPTURE,
    IFID_HOLD,
    IFID_BUBBLE
  } ifid_op_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: captures, holds, or bubbles instr/pc4/valid.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  ifid_op_e           op,
  input  logic [INSTR_W-1:0] instr,
  input  logic [31:0]        pc4,
  output logic [INSTR_W-1:0] held_instr,
  output logic [31:0]        held_pc4,
  output logic               valid
);

  // Register update; a bubble carries a NOP with no PC attached.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_instr <= NOP;
      held_pc4   <= '0;
      valid      <= 1'b0;
    end else begin
      unique case (op)
        IFID_CAPTURE: begin
          held_instr <= instr;
          held_pc4   <= pc4;
          valid      <= 1'b1;
        end
        IFID_BUBBLE: begin
          held_instr <= NOP;
          held_pc4   <= '0;
          valid      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC selection, ROM window fault trap,
// fetch counter, and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  input  logic               jump,
  input  logic [31:0]        jump_target,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [31:0]        pc_addr,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               fetch_fault,
  output logic [31:0]        fetch_count
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] count;
  logic        fault;
  logic        redirect;
  logic        illegal;
  ifid_op_e    op;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = jump | branch_taken;

  // Next-PC selection: jump beats branch, branch beats stall.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)              next_pc = jump_target;
    else if (branch_taken) next_pc = branch_target;
    else if (stall)        next_pc = pc;
  end

  assign illegal = (next_pc[1:0] != 2'b00) || (next_pc > LAST_PC);

  // IF/ID action: a latched fault, redirect or flush bubbles; stall holds.
  always_comb begin
    op = IFID_CAPTURE;
    if (fault || redirect || flush) op = IFID_BUBBLE;
    else if (stall)                 op = IFID_HOLD;
  end

  // PC, sticky fault and capture counter; a faulting target never reaches the PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      fault <= 1'b0;
      count <= '0;
    end else if (!fault) begin
      if (illegal) fault <= 1'b1;
      else         pc    <= next_pc;
      if (op == IFID_CAPTURE) count <= count + 32'd1;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .instr      (instr_in),
    .pc4        (pc_plus4),
    .held_instr (if_id_instr),
    .held_pc4   (if_id_pc4),
    .valid      (if_id_valid)
  );

  assign pc_addr     = pc;
  assign fetch_fault = fault;
  assign fetch_count = count;

endmodule
